// File: rtl/stream_window_gen_if.sv
// Pixel stream in, KxK window stream out, for stream_window_gen.
// master drives the raster stream; slave is the window generator.
interface stream_window_gen_if #(
   parameter int unsigned PIXEL_W = 8,
   parameter int unsigned K       = 3
);
   logic                       en;
   logic                       hsync;
   logic                       vsync;
   logic [PIXEL_W-1:0]         data_in;
   logic [K*K*PIXEL_W-1:0]     win_out;
   logic                       win_valid;
   logic signed [31:0]         cx;
   logic signed [31:0]         cy;
   logic [31:0]                frame;
   logic                       sync_err;

   modport master (
      output en, hsync, vsync, data_in,
      input  win_out, win_valid, cx, cy, frame, sync_err
   );

   modport slave (
      input  en, hsync, vsync, data_in,
      output win_out, win_valid, cx, cy, frame, sync_err
   );
endinterface

// File: rtl/stream_window_gen.sv
// KxK sliding-window generator: raster position tracking, K-1 line memories,
// KxK tap shift array and one registered window per accepted pixel.
module stream_window_gen #(
   parameter int unsigned PIXEL_W      = 8,
   parameter int unsigned FRAME_WIDTH  = 640,
   parameter int unsigned FRAME_HEIGHT = 480,
   parameter int unsigned K            = 3,
   parameter int unsigned BORDER_MODE  = 0
) (
   input logic               clk,
   input logic               reset,
   stream_window_gen_if.slave bus
);
   localparam int unsigned XW    = $clog2(FRAME_WIDTH + 1);
   localparam int unsigned AW    = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam int unsigned YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int unsigned HALF  = (K - 1) / 2;
   localparam int unsigned WIN_W = K * K * PIXEL_W;

   logic [XW-1:0]      x_q;
   logic [YW-1:0]      y_q;
   logic [31:0]        frame_q;
   logic               sync_err_q;
   logic [PIXEL_W-1:0] tap_q [K][K];
   logic [PIXEL_W-1:0] tap_d [K][K];
   logic [PIXEL_W-1:0] line_mem [K-1][FRAME_WIDTH];
   logic [WIN_W-1:0]   win_q;
   logic [WIN_W-1:0]   win_d;
   logic               win_valid_q;
   logic [31:0]        cx_q;
   logic [31:0]        cy_q;

   logic               accept_c;
   logic               line_full_c;
   logic               pix_ok_c;
   logic               win_ok_c;
   logic [AW-1:0]      addr_c;

   // Accept qualification, next tap array and border-masked window
   always_comb begin
      accept_c    = bus.en & ~bus.hsync & ~bus.vsync;
      line_full_c = (x_q == XW'(FRAME_WIDTH));
      pix_ok_c    = accept_c & ~line_full_c;
      addr_c      = AW'(x_q);
      win_ok_c    = (BORDER_MODE != 0) ||
                    ((32'(x_q) >= 32'(K - 1)) && (32'(y_q) >= 32'(K - 1)));

      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            tap_d[r][c] = tap_q[r][c+1];
         end
      end
      for (int r = 0; r < K - 1; r++) begin
         tap_d[r][K-1] = line_mem[K-2-r][addr_c];
      end
      tap_d[K-1][K-1] = bus.data_in;

      // Taps mapping above row 0 or left of column 0 read as zero
      win_d = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            if ((32'(y_q) + 32'(r) >= 32'(K - 1)) && (32'(x_q) + 32'(c) >= 32'(K - 1))) begin
               win_d[(r*K+c)*PIXEL_W +: PIXEL_W] = tap_d[r][c];
            end
         end
      end
   end

   // Position counters, tap array and registered window outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q         <= '0;
         y_q         <= '0;
         frame_q     <= '0;
         sync_err_q  <= 1'b0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         cx_q        <= '0;
         cy_q        <= '0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               tap_q[r][c] <= '0;
            end
         end
      end else begin
         win_valid_q <= 1'b0;
         if (bus.en) begin
            if (bus.vsync) begin
               x_q        <= '0;
               y_q        <= '0;
               frame_q    <= frame_q + 32'd1;
               sync_err_q <= 1'b0;
            end else if (bus.hsync) begin
               x_q <= '0;
               if (y_q == YW'(FRAME_HEIGHT - 1)) begin
                  sync_err_q <= 1'b1;
               end else begin
                  y_q <= y_q + YW'(1);
               end
            end else if (line_full_c) begin
               sync_err_q <= 1'b1;
            end else begin
               x_q   <= x_q + XW'(1);
               tap_q <= tap_d;
               if (win_ok_c) begin
                  win_valid_q <= 1'b1;
                  win_q       <= win_d;
                  cx_q        <= 32'(x_q) - 32'(HALF);
                  cy_q        <= 32'(y_q) - 32'(HALF);
               end
            end
         end
      end
   end

   // Line memories shift down one line per accepted pixel; reads see pre-write data
   always_ff @(posedge clk) begin
      if (pix_ok_c) begin
         line_mem[0][addr_c] <= bus.data_in;
         for (int j = 1; j < K - 1; j++) begin
            line_mem[j][addr_c] <= line_mem[j-1][addr_c];
         end
      end
   end

   assign bus.win_out   = win_q;
   assign bus.win_valid = win_valid_q;
   assign bus.cx        = cx_q;
   assign bus.cy        = cy_q;
   assign bus.frame     = frame_q;
   assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_stream_window_gen.sv
// Bench for stream_window_gen: VALID_ONLY and ZERO_PAD instances on one stream,
// compared each cycle against an image-array reference model.
module tb_stream_window_gen;
   localparam int PW    = 8;
   localparam int W     = 8;
   localparam int H     = 6;
   localparam int K     = 3;
   localparam int HALF  = (K - 1) / 2;
   localparam int WIN_W = K * K * PW;

   logic clk;
   logic reset;
   logic en, hs, vs;
   logic [PW-1:0] din;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int                 mx, my;
   logic [31:0]        mframe;
   logic               merr;
   logic [PW-1:0]      img [H][W];
   logic [WIN_W-1:0]   ev_win, ez_win;
   logic               ev_valid, ez_valid;
   logic signed [31:0] ev_cx, ev_cy, ez_cx, ez_cy;

   stream_window_gen_if #(.PIXEL_W(PW), .K(K)) if_v ();
   stream_window_gen_if #(.PIXEL_W(PW), .K(K)) if_z ();

   assign if_v.en = en;  assign if_v.hsync = hs;  assign if_v.vsync = vs;  assign if_v.data_in = din;
   assign if_z.en = en;  assign if_z.hsync = hs;  assign if_z.vsync = vs;  assign if_z.data_in = din;

   stream_window_gen #(.PIXEL_W(PW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .K(K), .BORDER_MODE(0))
      dut_v (.clk(clk), .reset(reset), .bus(if_v));
   stream_window_gen #(.PIXEL_W(PW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .K(K), .BORDER_MODE(1))
      dut_z (.clk(clk), .reset(reset), .bus(if_z));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Window seen from image coordinates; anything outside the frame is zero
   function automatic logic [WIN_W-1:0] mwin(input int x, input int y);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            if ((y - (K - 1) + r >= 0) && (x - (K - 1) + c >= 0))
               w[(r*K+c)*PW +: PW] = img[y-(K-1)+r][x-(K-1)+c];
         end
      end
      return w;
   endfunction

   task automatic model_reset();
      mx = 0; my = 0; mframe = '0; merr = 1'b0;
      ev_win = '0; ez_win = '0; ev_valid = 1'b0; ez_valid = 1'b0;
      ev_cx = '0; ev_cy = '0; ez_cx = '0; ez_cy = '0;
   endtask

   task automatic check_all();
      chk("v_valid", if_v.win_valid, ev_valid);
      chk("v_win",   if_v.win_out,   ev_win);
      chk("v_cx",    if_v.cx,        ev_cx);
      chk("v_cy",    if_v.cy,        ev_cy);
      chk("v_frame", if_v.frame,     mframe);
      chk("v_err",   if_v.sync_err,  merr);
      chk("z_valid", if_z.win_valid, ez_valid);
      chk("z_win",   if_z.win_out,   ez_win);
      chk("z_cx",    if_z.cx,        ez_cx);
      chk("z_cy",    if_z.cy,        ez_cy);
      chk("z_frame", if_z.frame,     mframe);
      chk("z_err",   if_z.sync_err,  merr);
   endtask

   // One clock: drive inputs, step the model, compare just after the edge
   task automatic cyc(input logic te, input logic ths, input logic tvs, input logic [PW-1:0] td);
      en = te; hs = ths; vs = tvs; din = td;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      ez_valid = 1'b0;
      if (te) begin
         if (tvs) begin
            mx = 0; my = 0; mframe = mframe + 32'd1; merr = 1'b0;
         end else if (ths) begin
            mx = 0;
            if (my == H - 1) merr = 1'b1;
            else my++;
         end else if (mx == W) begin
            merr = 1'b1;
         end else begin
            img[my][mx] = td;
            ez_valid = 1'b1;
            ez_win   = mwin(mx, my);
            ez_cx    = 32'(mx - HALF);
            ez_cy    = 32'(my - HALF);
            if (mx >= K - 1 && my >= K - 1) begin
               ev_valid = 1'b1;
               ev_win   = ez_win;
               ev_cx    = ez_cx;
               ev_cy    = ez_cy;
            end
            mx++;
         end
      end
      check_all();
      en = 1'b0; hs = 1'b0; vs = 1'b0;
   endtask

   task automatic idle_garbage();
      cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
   endtask

   // Line of n pixels valued {y,x}, optional en=0 cycle before each accept
   task automatic send_line(input int yv, input int n, input bit toggle, input bit hs_after);
      int pv, pz;
      pv = 0; pz = 0;
      for (int x = 0; x < n; x++) begin
         if (toggle) begin
            idle_garbage();
            pv += int'(if_v.win_valid);
            pz += int'(if_z.win_valid);
         end
         cyc(1'b1, 1'b0, 1'b0, 8'(yv * 16 + x));
         pv += int'(if_v.win_valid);
         pz += int'(if_z.win_valid);
         if (yv == 2 && x == 2) begin
            chk("v_first_win", if_v.win_out, 72'h222120121110020100);
            chk("v_first_cx",  if_v.cx, 32'd1);
            chk("v_first_cy",  if_v.cy, 32'd1);
         end
         if (yv == 1 && x == 1) chk("z_win_11", if_z.win_out, 72'h111000010000000000);
         if (yv == 0 && x == 0) chk("z_win_00", if_z.win_out, '0);
      end
      if (n >= W) begin
         chk("v_pulses", 32'(pv), 32'((yv >= 2) ? W - 2 : 0));
         chk("z_pulses", 32'(pz), 32'(W));
      end
      if (hs_after) begin
         if (toggle) idle_garbage();
         cyc(1'b1, 1'b1, 1'b0, '0);
      end
   endtask

   task automatic send_frame(input bit toggle);
      cyc(1'b1, 1'b0, 1'b1, '0);
      for (int y = 0; y < H; y++) send_line(y, W, toggle, y < H - 1);
   endtask

   // Full frame of random pixels with random idle cycles carrying junk syncs
   task automatic rand_frame();
      cyc(1'b1, 1'b0, 1'b1, '0);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            while ($urandom_range(0, 2) == 0) idle_garbage();
            cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
         end
         if (y < H - 1) cyc(1'b1, 1'b1, 1'b0, '0);
      end
   endtask

   initial begin
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) img[y][x] = '0;
      reset = 1'b1; en = 1'b0; hs = 1'b0; vs = 1'b0; din = '0;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Directed frame, both border modes in parallel
      send_frame(1'b0);
      // Same frame with en toggling every cycle
      send_frame(1'b1);

      // Ninth pixel on a line is dropped and flags an error
      cyc(1'b1, 1'b0, 1'b1, '0);
      send_line(0, W, 1'b0, 1'b1);
      send_line(1, W, 1'b0, 1'b1);
      send_line(2, W + 1, 1'b0, 1'b0);
      chk("err_9th_pixel", if_v.sync_err, 1'b1);
      chk("no_9th_pulse",  if_z.win_valid, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, '0);
      chk("err_cleared", if_z.sync_err, 1'b0);
      // Too many hsyncs: y sticks at the last line
      for (int y = 0; y < H; y++) send_line(y, W, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("err_extra_hsync", if_v.sync_err, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, '0);
      chk("err_vsync_clear", if_v.sync_err, 1'b0);

      // Simultaneous hsync+vsync ends line 3 and starts a new frame
      for (int y = 0; y < 4; y++) send_line(y, W, 1'b0, y < 3);
      cyc(1'b1, 1'b1, 1'b1, '0);
      send_line(0, W, 1'b0, 1'b0);
      chk("zp_rows01_zero", if_z.win_out[2*K*PW-1:0], '0);
      cyc(1'b1, 1'b1, 1'b0, '0);

      // Asynchronous reset in the middle of line 3
      cyc(1'b1, 1'b0, 1'b1, '0);
      for (int y = 0; y < 3; y++) send_line(y, W, 1'b0, 1'b1);
      send_line(3, 4, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
      for (int y = 0; y < 3; y++) send_line(y, W, 1'b0, y < 2);
      cyc(1'b1, 1'b1, 1'b0, '0);

      for (int f = 0; f < 3; f++) rand_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
